led_matrix_scanner: RTL and testbench
=====================================

// Module: led_matrix_scanner
// PURPOSE
//   Drives the 6x6 LED matrix of the Snake Game Arcade from the 36-bit frame produced by the game datapath (db_leds).
//   Sits directly downstream of SGA: it captures the frame into a shadow buffer at each frame boundary, then
//   time-multiplexes it one row at a time onto row and column pins.
//   Each row's dwell interval begins with an anti-ghosting blank window.
// PARAMETERS
//   ROWS          6      matrix rows; frame row r = frame[r*COLS +: COLS]
//   COLS          6      matrix columns; bit c of a row slice = column c
//   DWELL_CYCLES  50000  clock cycles per row (1 ms at 50 MHz); must be > BLANK_CYCLES
//   BLANK_CYCLES  2      blanked cycles at start of every row dwell; must be >= 1
// PORTS
//   clock        in   1          system clock, 50 MHz, rising edge
//   restart      in   1          synchronous active-high reset
//   enable       in   1          1 = scan running, 0 = display blanked and scan parked
//   frame        in   ROWS*COLS  live frame from SGA; 1 = LED lit
//   rows         out  ROWS       row anodes, one-hot active-high
//   cols         out  COLS       column cathodes, active-low (0 = sink, LED lit)
//   frame_start  out  1          one-cycle pulse on first cycle of each new frame (row 0 blank)
//   db_row       out  3          current row index, debug
//   db_state     out  2          FSM state encoding, debug: IDLE=0, BLANK=1, DRIVE=2
// BEHAVIOUR
//   - Reset values (restart=1): state IDLE, row=0, dwell counter=0, shadow=0, rows=0, cols=all 1,
//     frame_start=0, db_row=0. Restart has priority over all other inputs.
//   - All outputs are registered; they reflect state one clock after the causing edge.
//   - FSM states: IDLE, BLANK, DRIVE.
//   - IDLE: rows=0, cols=all 1, row=0, counter=0.
//       - Exit: enable=1 -> BLANK, row 0; shadow <= frame; frame_start=1 for that first BLANK cycle.
//   - BLANK: rows=0, cols=all 1.
//       - Duration: exactly BLANK_CYCLES cycles, then -> DRIVE.
//   - DRIVE: rows = one-hot(row); cols = ~shadow[row*COLS +: COLS].
//       - Duration: exactly DWELL_CYCLES-BLANK_CYCLES cycles.
//       - End of dwell, row < ROWS-1: row <= row+1, -> BLANK.
//       - End of dwell, row = ROWS-1: row wraps to 0, shadow <= frame, frame_start pulses, -> BLANK.
//   - Timing totals: each row occupies exactly DWELL_CYCLES cycles; a frame occupies ROWS*DWELL_CYCLES cycles.
//   - Tear-free: frame is sampled only at the frame boundary.
//       - Changes to frame mid-scan do not appear until the next frame.
//       - A frame value must be stable on the sampling cycle only.
//   - enable=0 in any state: -> IDLE on the next edge; outputs blanked; row and counter cleared.
//     Re-enable always restarts at row 0 with a fresh latch.
//   - Simultaneous enable fall with end of frame: enable wins; no latch and no frame_start pulse.
//   - Never more than one rows bit high; rows and active cols never change on the same cycle a blank begins.
//   - Counter width: clog2(DWELL_CYCLES). Row counter wraps modulo ROWS. No out-of-range row index is ever driven.
// CONFIGURATION
//   BRIGHTNESS_PWM_EN defined:
//     - Adds input brightness [2:0], sampled with the shadow latch at frame boundaries.
//     - Let p = cycles since DRIVE entry and D = DWELL_CYCLES-BLANK_CYCLES.
//     - Columns are driven only while p < (D*(brightness+1))>>3; otherwise cols=all 1 and rows stay one-hot.
//     - brightness=7 gives full duty. Reset value of the latched brightness is 7.
//   BRIGHTNESS_PWM_EN undefined:
//     - No brightness port; full duty for the whole DRIVE window.
// TESTING
//   Bench parameters: DWELL_CYCLES=8, BLANK_CYCLES=2.
//   1 Reset: restart=1 for 2 cycles, enable=1 -> rows=0, cols=6'b111111, frame_start=0, db_row=0, db_state=0.
//   2 Scan: frame=36'h0_0000_003F, enable=1 after reset ->
//       - frame_start pulses once.
//       - Row 0: 2 blank cycles, then 6 cycles of rows=6'b000001, cols=6'b000000.
//       - Rows 1..5: rows one-hot with cols=6'b111111.
//       - frame_start repeats every 48 cycles.
//   3 Tear-free: frame=36'h1 at latch, change to 36'h8_0000_0000 during row 2 ->
//       - Row 5 cols stay 6'b111111 in the current frame.
//       - Next frame: row 5 cols=6'b011111, row 0 cols=6'b111111.
//   4 Enable drop: deassert enable in row 3 DRIVE ->
//       - Next cycle: rows=0, cols=all 1, db_row=0, db_state=0.
//       - Re-assert: frame_start pulses and the scan restarts at row 0.
//   5 Mid-scan restart: restart=1 during row 4 DRIVE -> all outputs at reset values the following cycle.
//   6 BRIGHTNESS_PWM_EN with brightness=3 -> each DRIVE window (6 cycles) has cols active for exactly 3 cycles
//     ((6*4)>>3 = 3), then all 1.

Source files
------------

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed scanner for a ROWS x COLS LED matrix with a tear-free shadow frame buffer.
// Optional `BRIGHTNESS_PWM_EN adds a 3-bit brightness input that gates column drive inside each row.
module led_matrix_scanner #(
    parameter int ROWS         = 6,
    parameter int COLS         = 6,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 restart,
    input  logic                 enable,
`ifdef BRIGHTNESS_PWM_EN
    input  logic [2:0]           brightness,
`endif
    input  logic [ROWS*COLS-1:0] frame,
    output logic [ROWS-1:0]      rows,
    output logic [COLS-1:0]      cols,
    output logic                 frame_start,
    output logic [2:0]           db_row,
    output logic [1:0]           db_state
);

    localparam int CW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam int RW = (ROWS > 2) ? $clog2(ROWS) : 1;
    localparam int D  = DWELL_CYCLES - BLANK_CYCLES;

    typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, DRIVE = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         row_q, row_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ROWS*COLS-1:0]  shadow_q, shadow_d;
    logic [ROWS-1:0]       rows_q, rows_d;
    logic [COLS-1:0]       cols_q, cols_d;
    logic                  fs_q, fs_d;
    logic [COLS-1:0]       slice;
    logic                  latch;
    logic                  pwm_on;
`ifdef BRIGHTNESS_PWM_EN
    logic [2:0]            bright_q, bright_d;
    logic [31:0]           thr;
    logic [31:0]           pos;
`endif

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        latch    = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            row_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    row_d   = '0;
                    cnt_d   = '0;
                    latch   = 1'b1;
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(BLANK_CYCLES - 1))
                        state_d = DRIVE;
                end
                DRIVE: begin
                    // cnt runs across the whole dwell, so BLANK + DRIVE always totals DWELL_CYCLES
                    if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = BLANK;
                        if (row_q == RW'(ROWS - 1)) begin
                            row_d = '0;
                            latch = 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (latch)
            shadow_d = frame;
    end

`ifdef BRIGHTNESS_PWM_EN
    always_comb begin
        bright_d = latch ? brightness : bright_q;
        thr      = (32'(D) * (32'(bright_q) + 32'd1)) >> 3;
        pos      = 32'(cnt_d) - 32'(BLANK_CYCLES);
        pwm_on   = (pos < thr);
    end
`else
    assign pwm_on = 1'b1;
`endif

    // Outputs are computed from next-state values so they line up with the registered state
    always_comb begin
        slice  = '1;
        rows_d = '0;
        cols_d = '1;
        fs_d   = latch;
        for (int r = 0; r < ROWS; r++) begin
            if (row_d == RW'(r))
                slice = shadow_q[r*COLS +: COLS];
        end
        if (state_d == DRIVE) begin
            for (int r = 0; r < ROWS; r++)
                rows_d[r] = (row_d == RW'(r));
            if (pwm_on)
                cols_d = ~slice;
        end
    end

    always_ff @(posedge clock) begin
        if (restart) begin
            state_q  <= IDLE;
            row_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            rows_q   <= '0;
            cols_q   <= '1;
            fs_q     <= 1'b0;
`ifdef BRIGHTNESS_PWM_EN
            bright_q <= 3'd7;
`endif
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            rows_q   <= rows_d;
            cols_q   <= cols_d;
            fs_q     <= fs_d;
`ifdef BRIGHTNESS_PWM_EN
            bright_q <= bright_d;
`endif
        end
    end

    assign rows        = rows_q;
    assign cols        = cols_q;
    assign frame_start = fs_q;
    assign db_row      = 3'(row_q);
    assign db_state    = state_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner: a time-position model pushes expected outputs per cycle.
module tb_led_matrix_scanner;
    localparam int ROWS = 6;
    localparam int COLS = 6;
    localparam int DW   = 8;
    localparam int BC   = 2;
    localparam int FR   = ROWS * DW;

    logic        clock = 1'b0;
    logic        restart;
    logic        enable;
    logic [35:0] frame;
    logic [5:0]  rows;
    logic [5:0]  cols;
    logic        frame_start;
    logic [2:0]  db_row;
    logic [1:0]  db_state;
`ifdef BRIGHTNESS_PWM_EN
    logic [2:0]  brightness;
`endif

    always #5 clock = ~clock;

    led_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .DWELL_CYCLES(DW), .BLANK_CYCLES(BC)
    ) dut (
        .clock(clock),
        .restart(restart),
        .enable(enable),
`ifdef BRIGHTNESS_PWM_EN
        .brightness(brightness),
`endif
        .frame(frame),
        .rows(rows),
        .cols(cols),
        .frame_start(frame_start),
        .db_row(db_row),
        .db_state(db_state)
    );

    typedef struct packed {
        logic [5:0] rows;
        logic [5:0] cols;
        logic       fs;
        logic [2:0] row;
        logic [1:0] st;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          fs_count = 0;
    bit          m_run = 1'b0;
    int          m_t = 0;
    logic [35:0] m_shadow = '0;
    logic [2:0]  m_bright = 3'd7;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model works from absolute position m_t inside the running scan
    task automatic step();
        exp_t e;
        int   row;
        int   w;
        int   thr;
        e = '{rows: 6'd0, cols: 6'h3F, fs: 1'b0, row: 3'd0, st: 2'd0};
        if (restart) begin
            m_run = 1'b0; m_t = 0; m_shadow = '0; m_bright = 3'd7;
        end else if (!enable) begin
            m_run = 1'b0;
        end else begin
            if (!m_run) begin m_run = 1'b1; m_t = 0; end
            else m_t++;
            if (m_t % FR == 0) begin
                m_shadow = frame;
`ifdef BRIGHTNESS_PWM_EN
                m_bright = brightness;
`endif
                e.fs = 1'b1;
            end
            row   = (m_t / DW) % ROWS;
            w     = m_t % DW;
            e.row = 3'(row);
            if (w < BC) begin
                e.st = 2'd1;
            end else begin
                e.st   = 2'd2;
                e.rows = 6'(1 << row);
                thr    = ((DW - BC) * (int'(m_bright) + 1)) >> 3;
                if ((w - BC) < thr)
                    e.cols = ~m_shadow[row*COLS +: COLS];
            end
        end
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        check("rows", rows, e.rows);
        check("cols", cols, e.cols);
        check("frame_start", frame_start, e.fs);
        check("db_row", db_row, e.row);
        check("db_state", db_state, e.st);
        if (frame_start) fs_count++;
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < 200; i++) begin
            if (m_run && (m_t % FR == target)) break;
            step();
        end
        check("reach_row", db_row, target / DW);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        restart = 1'b1;
        enable  = 1'b1;
        frame   = 36'h0_0000_003F;
`ifdef BRIGHTNESS_PWM_EN
        brightness = 3'd7;
`endif
        repeat (2) step();

        restart  = 1'b0;
        fs_count = 0;
        repeat (2*FR + 4) step();
        check("fs_count", fs_count, 3);

        enable = 1'b0;
        step();
        frame  = 36'h1;
        enable = 1'b1;
        step();
        run_until(2*DW + 3);
        frame = 36'h8_0000_0000;
        repeat (FR + 10) step();

        run_until(FR - 1);
        enable = 1'b0;
        step();
        repeat (3) step();
        enable = 1'b1;
        for (int f = 0; f < 4; f++) begin
            frame = {4'($urandom), 32'($urandom)};
            repeat (FR) step();
        end

        run_until(3*DW + 4);
        enable = 1'b0;
        step();
        step();
        enable = 1'b1;
        repeat (20) step();

        run_until(4*DW + 3);
        restart = 1'b1;
        step();
        restart = 1'b0;
        repeat (FR + 5) step();

`ifdef BRIGHTNESS_PWM_EN
        brightness = 3'd3;
        run_until(FR - 1);
        repeat (2*FR) step();
        brightness = 3'd0;
        repeat (2*FR) step();
`endif

        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
